// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared state type and Bagman image defaults
// for the HPS ROM download front end.
package rom_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } state_t;

    localparam logic [17:0] BAGMAN_ROM_SIZE   = 18'd65536;
    localparam int unsigned BAGMAN_RESET_HOLD = 16;
    localparam int unsigned BAGMAN_AW         = 17;
    localparam logic [17:0] BYTE_COUNT_MAX    = '1;

endpackage

// File: rtl/rom_loader_hold_counter.sv
// reset_hold_counter: loads HOLD-1 on start, counts down while
// enabled, flags done on the last enabled cycle.
module reset_hold_counter #(
    parameter int unsigned HOLD = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_start,
    input  logic i_en,
    output logic o_done
);

    localparam int unsigned CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(HOLD - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= LOAD_VAL;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = i_en && (r_count == '0);

endmodule

// File: rtl/rom_loader.sv
// rom_loader: filters the HPS ioctl byte stream onto the core ROM
// port and keeps the core in reset until a download has finished.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [17:0] ROM_SIZE   = BAGMAN_ROM_SIZE,
    parameter int unsigned RESET_HOLD = BAGMAN_RESET_HOLD,
    parameter int unsigned AW         = BAGMAN_AW
) (
    input  logic          i_clk_sys,
    input  logic          i_reset,
    input  logic          i_ioctl_download,
    input  logic          i_ioctl_wr,
    input  logic [24:0]   i_ioctl_addr,
    input  logic [7:0]    i_ioctl_dout,
    output logic [AW-1:0] o_dn_addr,
    output logic [7:0]    o_dn_data,
    output logic          o_dn_wr,
    output logic          o_core_reset,
    output logic          o_loaded,
    output logic          o_size_err,
    output logic [17:0]   o_byte_count
);

    state_t        r_state;
    logic          r_dl_q;
    logic          r_armed;
    logic [AW-1:0] r_dn_addr;
    logic [7:0]    r_dn_data;
    logic          r_dn_wr;
    logic          r_core_reset;
    logic          r_loaded;
    logic          r_size_err;
    logic [17:0]   r_byte_count;

    logic          w_rise;
    logic          w_fall;
    logic          w_active;
    logic          w_in_range;
    logic          w_accept;
    logic          w_oor;
    logic [17:0]   w_cnt_inc;
    logic [17:0]   w_cnt_next;
    logic          w_hold_start;
    logic          w_hold_done;

    // r_armed keeps a download caught mid-way by reset from re-entering LOAD
    assign w_rise     = i_ioctl_download & ~r_dl_q & r_armed;
    assign w_fall     = ~i_ioctl_download & r_dl_q;
    assign w_active   = (r_state == ST_LOAD) | w_rise;
    assign w_in_range = {7'd0, ROM_SIZE} > i_ioctl_addr;
    assign w_accept   = i_ioctl_download & i_ioctl_wr & w_in_range & w_active;
    assign w_oor      = i_ioctl_download & i_ioctl_wr & ~w_in_range & w_active;
    assign w_cnt_inc  = (r_byte_count == BYTE_COUNT_MAX) ?
                        r_byte_count : r_byte_count + 18'd1;
    assign w_cnt_next = w_accept ? w_cnt_inc : r_byte_count;

    assign w_hold_start = w_fall & (r_state == ST_LOAD);

    reset_hold_counter #(
        .HOLD (RESET_HOLD)
    ) u_hold (
        .i_clk   (i_clk_sys),
        .i_reset (i_reset),
        .i_start (w_hold_start),
        .i_en    (r_state == ST_HOLD),
        .o_done  (w_hold_done)
    );

    always_ff @(posedge i_clk_sys) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_dl_q       <= 1'b0;
            r_armed      <= 1'b0;
            r_dn_addr    <= '0;
            r_dn_data    <= '0;
            r_dn_wr      <= 1'b0;
            r_core_reset <= 1'b1;
            r_loaded     <= 1'b0;
            r_size_err   <= 1'b0;
            r_byte_count <= '0;
        end else begin
            r_dl_q  <= i_ioctl_download;
            r_dn_wr <= w_accept;
            if (!i_ioctl_download) begin
                r_armed <= 1'b1;
            end
            if (w_accept) begin
                r_dn_addr <= i_ioctl_addr[AW-1:0];
                r_dn_data <= i_ioctl_dout;
            end
            if (w_rise) begin
                r_state      <= ST_LOAD;
                r_core_reset <= 1'b1;
                r_byte_count <= w_accept ? 18'd1 : 18'd0;
                r_size_err   <= w_oor;
            end else begin
                unique case (r_state)
                    ST_LOAD: begin
                        r_byte_count <= w_cnt_next;
                        r_size_err   <= r_size_err | w_oor |
                                        (w_fall && (w_cnt_next != ROM_SIZE));
                        if (w_fall) begin
                            r_state <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (w_hold_done) begin
                            r_state      <= ST_RUN;
                            r_core_reset <= 1'b0;
                            r_loaded     <= 1'b1;
                        end
                    end
                    ST_IDLE, ST_RUN: begin
                    end
                endcase
            end
        end
    end

    assign o_dn_addr    = r_dn_addr;
    assign o_dn_data    = r_dn_data;
    assign o_dn_wr      = r_dn_wr;
    assign o_core_reset = r_core_reset;
    assign o_loaded     = r_loaded;
    assign o_size_err   = r_size_err;
    assign o_byte_count = r_byte_count;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed download scenarios with random data,
// checked every cycle against a behavioural model.
module tb_rom_loader;

    localparam int unsigned N    = 2048;
    localparam int unsigned HOLD = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        dl;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic [16:0] o_dn_addr;
    logic [7:0]  o_dn_data;
    logic        o_dn_wr;
    logic        o_core_reset;
    logic        o_loaded;
    logic        o_size_err;
    logic [17:0] o_byte_count;

    int n_pass  = 0;
    int n_total = 0;

    bit          m_prev, m_armed, m_sess, m_run, m_loaded, m_err, m_wr;
    int          m_since;
    int unsigned m_cnt;
    logic [16:0] m_addr;
    logic [7:0]  m_data;

    always #5 clk = ~clk;

    rom_loader #(
        .ROM_SIZE   (18'(N)),
        .RESET_HOLD (HOLD),
        .AW         (17)
    ) dut (
        .i_clk_sys        (clk),
        .i_reset          (rst),
        .i_ioctl_download (dl),
        .i_ioctl_wr       (wr),
        .i_ioctl_addr     (addr),
        .i_ioctl_dout     (dout),
        .o_dn_addr        (o_dn_addr),
        .o_dn_data        (o_dn_data),
        .o_dn_wr          (o_dn_wr),
        .o_core_reset     (o_core_reset),
        .o_loaded         (o_loaded),
        .o_size_err       (o_size_err),
        .o_byte_count     (o_byte_count)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Model: a session runs from an armed rise to its fall; the core is
    // released once HOLD clock edges have passed after the fall edge.
    task automatic model_step();
        bit rise, fall, act, acc, oor;
        if (rst) begin
            m_prev = 0; m_armed = 0; m_sess = 0; m_run = 0;
            m_loaded = 0; m_err = 0; m_since = -1; m_cnt = 0;
            m_addr = '0; m_data = '0; m_wr = 0;
        end else begin
            rise = dl && !m_prev && m_armed;
            fall = !dl && m_prev;
            act  = m_sess || rise;
            acc  = dl && wr && (addr < N) && act;
            oor  = dl && wr && (addr >= N) && act;
            m_wr = acc;
            if (acc) begin
                m_addr = addr[16:0];
                m_data = dout;
            end
            if (rise) begin
                m_sess = 1; m_run = 0; m_since = -1;
                m_cnt = acc ? 1 : 0;
                m_err = oor;
            end else if (m_sess) begin
                if (acc && m_cnt < 262143) m_cnt++;
                if (oor) m_err = 1;
                if (fall) begin
                    m_sess = 0;
                    m_since = 0;
                    if (m_cnt != N) m_err = 1;
                end
            end else if (m_since >= 0) begin
                m_since++;
                if (m_since == HOLD) begin
                    m_run = 1; m_loaded = 1; m_since = -1;
                end
            end
            if (!dl) m_armed = 1;
            m_prev = dl;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_step();
        chk("dn_wr", o_dn_wr, m_wr);
        chk("dn_addr", o_dn_addr, m_addr);
        chk("dn_data", o_dn_data, m_data);
        chk("core_reset", o_core_reset, !m_run);
        chk("loaded", o_loaded, m_loaded);
        chk("size_err", o_size_err, m_err);
        chk("byte_count", o_byte_count, m_cnt);
    endtask

    task automatic wr_byte(int unsigned a, int unsigned gap);
        wr = 1'b1;
        addr = 25'(a);
        dout = 8'($urandom);
        tick();
        wr = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic fall_and_release(string tag);
        int n;
        dl = 1'b0;
        wr = 1'b0;
        tick();
        n = 0;
        while (o_core_reset && n < 100) begin
            tick();
            n++;
        end
        chk(tag, n, HOLD);
    endtask

    initial begin
        rst = 1'b1; dl = 1'b0; wr = 1'b0; addr = '0; dout = '0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (1000) tick();
        chk("idle_core_reset", o_core_reset, 1);
        chk("idle_loaded", o_loaded, 0);

        dl = 1'b1;
        tick();
        for (int a = 0; a < N; a++) wr_byte(a, 3);
        chk("full_count", o_byte_count, N);
        fall_and_release("full_release");
        chk("full_err", o_size_err, 0);
        chk("full_loaded", o_loaded, 1);
        repeat (10) tick();

        dl = 1'b1;
        wr_byte($urandom_range(0, N - 1), 1);
        for (int i = 1; i < 100; i++)
            wr_byte($urandom_range(0, N - 1), $urandom_range(0, 3));
        dl = 1'b0;
        tick();
        chk("short_count", o_byte_count, 100);
        chk("short_err", o_size_err, 1);
        dl = 1'b1;
        repeat (5) tick();
        dl = 1'b0;
        chk("short_pre_err", o_size_err, 0);
        fall_and_release("short_release");

        dl = 1'b1;
        tick();
        for (int i = 0; i < 50; i++) begin
            if (i == 20) wr_byte(N, 1);
            if (i == 30) wr_byte(65536, 1);
            if (i == 40) wr_byte(70000, 1);
            wr_byte($urandom_range(0, N - 1), $urandom_range(0, 2));
        end
        chk("oor_count", o_byte_count, 50);
        chk("oor_err", o_size_err, 1);
        fall_and_release("oor_release");
        repeat (5) tick();

        dl = 1'b1;
        tick();
        chk("rerun_core_reset", o_core_reset, 1);
        chk("rerun_count", o_byte_count, 0);
        chk("rerun_err", o_size_err, 0);
        for (int i = 0; i < 10; i++) wr_byte(i, 0);
        dl = 1'b0;
        repeat (6) tick();
        dl = 1'b1;
        tick();
        chk("hold_rise_core_reset", o_core_reset, 1);
        chk("hold_rise_count", o_byte_count, 0);
        for (int a = 0; a < N; a++) wr_byte(a, 0);
        fall_and_release("hold_rise_release");
        chk("hold_rise_err", o_size_err, 0);

        dl = 1'b1;
        tick();
        for (int a = 0; a < 300; a++) wr_byte(a, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_count", o_byte_count, 0);
        chk("rst_dn_wr", o_dn_wr, 0);
        chk("rst_loaded", o_loaded, 0);
        for (int a = 300; a < 320; a++) wr_byte(a, 1);
        chk("rst_ignored_count", o_byte_count, 0);
        dl = 1'b0;
        repeat (40) tick();
        chk("rst_core_reset", o_core_reset, 1);
        dl = 1'b1;
        tick();
        for (int a = 0; a < N; a++) wr_byte(a, 0);
        fall_and_release("rst_fresh_release");
        chk("rst_fresh_loaded", o_loaded, 1);
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Sits between the HPS download interface (ioctl_*) and the Bagman core ROM download port (dn_*).
- Registers and filters the byte stream, counts bytes and checks the image size.
- Holds the core in reset from power-up until a valid download completes, then for RESET_HOLD further cycles.
- Replaces the ad-hoc download-edge reset logic in the top level with one verifiable block.

Parameters:
- ROM_SIZE, 18'd65536: expected image length in bytes; writes at or above this address are dropped.
- RESET_HOLD, 16: clk_sys cycles core_reset stays high after download end.
- AW, 17: width of dn_addr.

Ports:
- clk_sys  in  1  system clock (12 MHz domain)
- reset  in  1  synchronous, active-high
- ioctl_download  in  1  download active, level
- ioctl_wr  in  1  byte strobe, one clk_sys cycle
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- dn_addr  out  AW  registered ROM address to core
- dn_data  out  8  registered ROM data to core
- dn_wr  out  1  registered write strobe to core
- core_reset  out  1  reset to core; high until RUN
- loaded  out  1  sticky: at least one download completed since reset
- size_err  out  1  sticky per download: byte count != ROM_SIZE, or an out-of-range write
- byte_count  out  18  accepted bytes in current/last download

Behaviour:
- Clock and reset: one clock, clk_sys. reset is synchronous and active-high.
- Reset values: state=IDLE, dn_addr=0, dn_data=0, dn_wr=0, core_reset=1, loaded=0, size_err=0, byte_count=0, hold counter=0, dl_q=0.
- Edge detect: dl_q <= ioctl_download.
  - Rise = ioctl_download & ~dl_q.
  - Fall = ~ioctl_download & dl_q.
- Write path, 1-cycle latency:
  - Accept when ioctl_download & ioctl_wr & (ioctl_addr < ROM_SIZE).
  - On accept: next cycle dn_wr=1, dn_addr=ioctl_addr[AW-1:0], dn_data=ioctl_dout, byte_count+1.
  - Otherwise dn_wr=0; dn_addr/dn_data hold.
- Write filtering:
  - ioctl_wr with ioctl_download=0: ignored, no flag.
  - ioctl_wr with ioctl_addr >= ROM_SIZE while downloading: dropped, size_err<=1.
- States:
  - IDLE: core_reset=1. Rise -> LOAD.
  - LOAD: core_reset=1.
    - On Rise entry: byte_count<=0, size_err<=0; if a write is accepted in that same cycle, byte_count<=1.
    - Fall -> HOLD: hold counter<=0; size_err<=1 if final byte_count (including a write accepted in the Fall cycle) != ROM_SIZE.
  - HOLD: core_reset=1, counter increments each cycle.
    - When counter==RESET_HOLD-1 -> RUN, loaded<=1.
    - Rise in HOLD -> LOAD; counter discarded.
  - RUN: core_reset=0. Rise -> LOAD, core_reset=1 in the cycle after the rise.
- size_err does not block the reset release; the core runs and the flag is informational.
- A write accepted in the same cycle as Fall is still issued on dn_* the next cycle and counted.
- byte_count saturates at 2^18-1; no wrap.
- reset mid-LOAD or mid-HOLD: all state to reset values. A download still in progress is not re-entered until the next Rise.
- Overall release latency: core_reset falls exactly RESET_HOLD+1 cycles after the Fall cycle.

Decomposition:
- Shared package rom_loader_pkg:
  - state enum {IDLE, LOAD, HOLD, RUN}.
  - Default ROM_SIZE and RESET_HOLD constants for the Bagman image.
- One natural sub-module: reset_hold_counter. Parameterised down-counter with start/done; reusable by other cores for post-download reset stretching.
- Everything else stays flat.

Test Plan:
- Power-up, no download, 1000 cycles -> core_reset=1, dn_wr never asserted, loaded=0.
- Download of ROM_SIZE bytes, addr 0..ROM_SIZE-1, one write every 4 cycles -> each dn_wr is 1 cycle after ioctl_wr with matching addr/data; byte_count=65536; size_err=0; core_reset falls 17 cycles after the Fall cycle; loaded=1.
- Short download of 100 bytes -> byte_count=100, size_err=1 at Fall+1, core_reset still released after hold.
- Out-of-range writes, addr 65536 and 70000, mid-download -> no dn_wr for them, size_err=1, byte_count excludes them.
- Re-download while in RUN -> core_reset=1 the cycle after Rise, byte_count cleared, size_err cleared. Rise during HOLD -> back to LOAD, no release.
- reset asserted mid-LOAD at byte 300 -> next cycle state=IDLE, byte_count=0, dn_wr=0; remaining writes of that download are ignored; core_reset stays 1 until a fresh Rise/Fall.
